// File: rtl/nrdiv_seq.sv
// nrdiv_seq: sequential non-restoring integer divider, signed or unsigned
// per operation, with a start/busy/done handshake.
//
// One quotient bit is produced per clock over N ITER cycles. A single FIX
// cycle then corrects the remainder and applies the result signs. Total
// latency is N+1 cycles from the accept edge. Divide-by-zero completes on
// the accept edge itself.
//
// Parameters:
//   N          operand, quotient and remainder width (minimum 2)
//
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous active-low reset
//   start      request, sampled only while busy=0
//   signed_op  1 = two's-complement operation, 0 = unsigned (sampled with start)
//   dividend   numerator (sampled with start)
//   divisor    denominator (sampled with start)
//   quotient   registered quotient, held until the next completion
//   remainder  registered remainder (sign follows dividend)
//   busy       operation in progress
//   done       one-cycle pulse when results are valid
//   dbz        divide-by-zero flag, held with the results
//   ovf        (only with NRDIV_OVF_DETECT_EN) signed MIN / -1 overflow flag
//
// Optional feature macro: NRDIV_OVF_DETECT_EN
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start; divide-by-zero is resolved here
// ITER  | one non-restoring step per cycle, cnt = 0 .. N-1
// FIX   | remainder correction, sign application, done pulse
module nrdiv_seq #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         signed_op,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         busy,
  output logic         done,
  output logic         dbz
`ifdef NRDIV_OVF_DETECT_EN
  ,
  output logic         ovf
`endif
);

  localparam int CW = $clog2(N);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]    state;
  logic [N:0]    a;
  logic [N-1:0]  q;
  logic [N-1:0]  m;
  logic [CW-1:0] cnt;
  logic          sign_q;
  logic          sign_r;

  logic          dd_neg;
  logic          dv_neg;
  logic [N-1:0]  dd_mag;
  logic [N-1:0]  dv_mag;
  logic [N:0]    a_sh;
  logic [N:0]    a_step;
  logic [N:0]    a_fix;
  logic [N-1:0]  q_out;
  logic [N-1:0]  r_out;
  logic          cnt_last;

  // Magnitudes fit in N unsigned bits, including |MIN| = 2^(N-1).
  assign dd_neg = signed_op & dividend[N-1];
  assign dv_neg = signed_op & divisor[N-1];
  assign dd_mag = dd_neg ? -dividend : dividend;
  assign dv_mag = dv_neg ? -divisor  : divisor;

  // A is N+1 bits; the shift may wrap mod 2^(N+1) but the add/subtract
  // result always lands back in [-M, M-1], so the sign bit is exact.
  assign a_sh   = {a[N-1:0], q[N-1]};
  assign a_step = a[N] ? (a_sh + {1'b0, m}) : (a_sh - {1'b0, m});
  assign a_fix  = a[N] ? (a + {1'b0, m}) : a;

  assign q_out    = sign_q ? -q : q;
  assign r_out    = sign_r ? -a_fix[N-1:0] : a_fix[N-1:0];
  assign cnt_last = (cnt == CW'(N - 1));

`ifdef NRDIV_OVF_DETECT_EN
  logic ovf_pend;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      a         <= '0;
      q         <= '0;
      m         <= '0;
      cnt       <= '0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      dbz       <= 1'b0;
`ifdef NRDIV_OVF_DETECT_EN
      ovf       <= 1'b0;
      ovf_pend  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
`ifdef NRDIV_OVF_DETECT_EN
            ovf      <= 1'b0;
            ovf_pend <= signed_op && (dividend == {1'b1, {(N-1){1'b0}}}) &&
                        (divisor == '1);
`endif
            if (divisor == '0) begin
              quotient  <= '1;
              remainder <= dividend;
              dbz       <= 1'b1;
              done      <= 1'b1;
            end else begin
              a      <= '0;
              q      <= dd_mag;
              m      <= dv_mag;
              sign_q <= dd_neg ^ dv_neg;
              sign_r <= dd_neg;
              cnt    <= '0;
              busy   <= 1'b1;
              dbz    <= 1'b0;
              state  <= S_ITER;
            end
          end
        end
        S_ITER: begin
          a   <= a_step;
          q   <= {q[N-2:0], ~a_step[N]};
          cnt <= cnt + CW'(1);
          if (cnt_last) state <= S_FIX;
        end
        S_FIX: begin
          a         <= a_fix;
          quotient  <= q_out;
          remainder <= r_out;
          done      <= 1'b1;
          busy      <= 1'b0;
          state     <= S_IDLE;
`ifdef NRDIV_OVF_DETECT_EN
          ovf       <= ovf_pend;
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nrdiv_seq.sv
// Scoreboard bench for nrdiv_seq (N=8). Stimulus pushes hand-computed
// expected results; a negedge monitor pops one entry per done pulse.
module tb_nrdiv_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       signed_op = 1'b0;
  logic [7:0] dividend = 8'h00;
  logic [7:0] divisor = 8'h00;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       busy;
  logic       done;
  logic       dbz;
`ifdef NRDIV_OVF_DETECT_EN
  logic       ovf;
`endif

  nrdiv_seq #(.N(8)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .signed_op(signed_op),
    .dividend(dividend),
    .divisor(divisor),
    .quotient(quotient),
    .remainder(remainder),
    .busy(busy),
    .done(done),
    .dbz(dbz)
`ifdef NRDIV_OVF_DETECT_EN
    ,
    .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
    logic       ovf;
    int         lat;
    int         acc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Monitor: one scoreboard entry per done pulse.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done: got done=1 expected no pending operation (t=%0t)", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", {24'h0, quotient}, {24'h0, e.q});
        chk("remainder", {24'h0, remainder}, {24'h0, e.r});
        chk("dbz", {31'h0, dbz}, {31'h0, e.dbz});
        chk("done_delay", cyc - e.acc, e.lat);
`ifdef NRDIV_OVF_DETECT_EN
        chk("ovf", {31'h0, ovf}, {31'h0, e.ovf});
`endif
      end
    end
  end

  // Pulse start for one cycle from a negedge; operands are scrambled
  // afterwards so late re-sampling would be visible.
  task automatic drive(input logic sg, input logic [7:0] dd, input logic [7:0] dv);
    signed_op = sg;
    dividend  = dd;
    divisor   = dv;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    dividend  = 8'h5A;
    divisor   = 8'hA5;
    signed_op = ~sg;
  endtask

  task automatic send(input logic sg, input logic [7:0] dd, input logic [7:0] dv,
                      input logic [7:0] eq, input logic [7:0] er,
                      input logic ed, input logic eo);
    exp_t e;
    e.q   = eq;
    e.r   = er;
    e.dbz = ed;
    e.ovf = eo;
    e.lat = ed ? 0 : 9;
    e.acc = cyc + 1;
    sb.push_back(e);
    drive(sg, dd, dv);
  endtask

  // Count busy cycles after the accept edge; ends on the done cycle.
  task automatic wait_busy(input int expn);
    int n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("busy_cycles", n, expn);
  endtask

  task automatic run(input logic sg, input logic [7:0] dd, input logic [7:0] dv,
                     input logic [7:0] eq, input logic [7:0] er,
                     input logic ed, input logic eo);
    send(sg, dd, dv, eq, er, ed, eo);
    wait_busy(ed ? 0 : 9);
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_quotient", {24'h0, quotient}, 32'h0);
    chk("rst_remainder", {24'h0, remainder}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_dbz", {31'h0, dbz}, 32'h0);
    reset = 1'b1;
    @(negedge clk);

    //  sg  dividend divisor  quo    rem    dbz  ovf
    run(0, 8'd200, 8'd7,    8'd28, 8'd4,  0, 0);
    run(1, 8'hF9,  8'h02,   8'hFD, 8'hFF, 0, 0);
    run(1, 8'h07,  8'hFE,   8'hFD, 8'h01, 0, 0);
    run(1, 8'hF8,  8'hFC,   8'h02, 8'h00, 0, 0);
    run(0, 8'd13,  8'd0,    8'hFF, 8'h0D, 1, 0);
    run(1, 8'd13,  8'd0,    8'hFF, 8'h0D, 1, 0);
    run(1, 8'h80,  8'hFF,   8'h80, 8'h00, 0, 1);
    run(0, 8'd10,  8'd3,    8'd3,  8'd1,  0, 0);
    run(0, 8'hFF,  8'h01,   8'hFF, 8'h00, 0, 0);
    run(0, 8'h00,  8'd5,    8'h00, 8'h00, 0, 0);
    run(1, 8'h7F,  8'h80,   8'h00, 8'h7F, 0, 0);
    run(1, 8'h80,  8'h03,   8'hD6, 8'hFE, 0, 0);
    run(0, 8'hFF,  8'h10,   8'h0F, 8'h0F, 0, 0);
    run(0, 8'd100, 8'd200,  8'd0,  8'd100, 0, 0);
    run(0, 8'h80,  8'hFF,   8'h00, 8'h80, 0, 0);
    run(1, 8'hFF,  8'hFF,   8'h01, 8'h00, 0, 0);
    run(0, 8'hFF,  8'hFF,   8'h01, 8'h00, 0, 0);

    // start while busy must be ignored
    send(0, 8'd100, 8'd9, 8'd11, 8'd1, 0, 0);
    repeat (3) @(negedge clk);
    drive(1, 8'd50, 8'd5);
    wait_busy(5);
    @(negedge clk);

    // back-to-back: second start issued in the done cycle
    send(0, 8'd250, 8'd25, 8'd10, 8'd0, 0, 0);
    wait_busy(9);
    chk("b2b_done_seen", {31'h0, done}, 32'h1);
    send(1, 8'h9C, 8'h07, 8'hF2, 8'hFE, 0, 0);
    wait_busy(9);
    @(negedge clk);

    // reset during ITER cycle 4 aborts with no done
    drive(0, 8'd200, 8'd7);
    repeat (4) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort_busy", {31'h0, busy}, 32'h0);
    chk("abort_done", {31'h0, done}, 32'h0);
    chk("abort_quotient", {24'h0, quotient}, 32'h0);
    chk("abort_remainder", {24'h0, remainder}, 32'h0);
    chk("abort_dbz", {31'h0, dbz}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);

    run(0, 8'd10, 8'd3, 8'd3, 8'd1, 0, 0);

    chk("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nrdiv_seq.md
Name: nrdiv_seq

Overview:
- Parametrised, sequential, non-restoring integer divider with a start/busy/done handshake.
- Performs signed or unsigned division, selected per operation.
- Produces one quotient bit per clock, followed by a single remainder-correction and sign-fix cycle.
- Successor to the team's fixed-width unsigned divider. Used by datapath blocks that need an N-bit quotient and remainder with a known, fixed latency.

Parameters:
- N, 8: operand, quotient and remainder width in bits; minimum 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset; clears all state immediately.
- start  in  1  request; sampled only while busy=0.
- signed_op  in  1  1 = two's-complement division, 0 = unsigned; sampled with start.
- dividend  in  N  numerator; sampled with start.
- divisor  in  N  denominator; sampled with start.
- quotient  out  N  registered result; held until the next accepted start.
- remainder  out  N  registered result; held until the next accepted start.
- busy  out  1  high while an operation is in progress.
- done  out  1  single-cycle pulse when quotient and remainder become valid.
- dbz  out  1  divide-by-zero flag; valid with done, held with the results.

Behaviour:
- Reset values (reset=0): quotient=0, remainder=0, busy=0, done=0, dbz=0; state IDLE; internal A, Q, M and cnt cleared.
- Reset mid-operation aborts the operation with no done pulse.
- States and transitions:
  - IDLE -> ITER: on start=1 with divisor!=0.
  - ITER -> ITER: while cnt < N-1.
  - ITER -> FIX: on the edge where cnt = N-1.
  - FIX -> IDLE: unconditional.
- Accept edge (IDLE, start=1, divisor!=0):
  - A (N+1 bits) <= 0.
  - Q <= |dividend|, M <= |divisor|; absolute values taken only when signed_op=1.
  - Latch sign_q = sign(dividend) XOR sign(divisor) and sign_r = sign(dividend); both forced to 0 when unsigned.
  - cnt <= 0, busy <= 1, dbz <= 0.
- ITER edge:
  - {A,Q} shifts left 1.
  - If the old A was non-negative, A = shifted A - M; otherwise A = shifted A + M.
  - Q[0] = NOT new A[N].
  - cnt increments.
- FIX edge:
  - If A is negative, A += M.
  - quotient <= sign_q ? -Q : Q.
  - remainder <= sign_r ? -A[N-1:0] : A[N-1:0].
  - done <= 1 for one cycle, busy <= 0.
- Latency: with start accepted at edge 0, done is high in the cycle following edge N+1 (N+1 cycles). busy is high from edge 0 to edge N+1.
- |MIN| = 2^(N-1) is handled as an N-bit unsigned magnitude; no extra width is required.
- Remainder sign always follows the dividend; a zero remainder is reported as 0.
- Divide by zero, detected at the accept edge:
  - No ITER cycles; quotient <= all ones, remainder <= dividend unchanged, dbz <= 1.
  - done <= 1 on the accept edge itself (1-cycle latency); busy stays 0.
- start while busy=1 is ignored; operands are not re-sampled.
- start in the same cycle that done is high is accepted; a back-to-back operation begins.
- Results and dbz persist until the next accepted start overwrites them.
- Signed MIN / -1 without the optional feature: quotient = MIN (wraps), remainder = 0, no flag.

Optional Feature:
- Macro NRDIV_OVF_DETECT_EN.
- When defined:
  - Adds output port ovf (1 bit), reset value 0.
  - Set at the FIX edge when signed_op=1, dividend = MIN and divisor = all ones; cleared at every accepted start.
  - Quotient and remainder values are unchanged (MIN, 0).
- When undefined: the ovf port does not exist and the logic is identical otherwise.

Test Plan:
- N=8, unsigned 200/7 -> quotient=28, remainder=4, dbz=0; done pulses exactly 9 cycles after the start edge; busy high for 9 cycles.
- N=8, signed -7/2 -> quotient=0xFD (-3), remainder=0xFF (-1); signed 7/-2 -> quotient=0xFD, remainder=0x01; signed -8/-4 -> quotient=0x02, remainder=0x00.
- N=8, 13/0 (unsigned and signed) -> done on the next edge, quotient=0xFF, remainder=0x0D, dbz=1, busy never asserted.
- N=8, signed -128/-1 -> quotient=0x80, remainder=0x00; with NRDIV_OVF_DETECT_EN, ovf=1 alongside done; then 10/3 -> ovf=0, quotient=3, remainder=1.
- Start pulsed mid-operation with new operands -> ignored, original result delivered. Assert reset at ITER cycle 4 -> outputs 0 immediately, no done. Back-to-back start during done -> second result correct after 9 more cycles.
- N=16 regression, 10k random signed/unsigned operands including 0, MIN, -1, all ones -> results match a reference model, done latency 17 cycles.
